// File: rtl/gauss_pkg.sv
// Shared constants and types for the 3x3 Gaussian blur stage of the canny chain.
package gauss_pkg;
  localparam int W_SIDE = 1;
  localparam int W_MID  = 2;
  localparam int KSHIFT = 4;
  localparam int ROUND  = 8;
  localparam int PIX_W  = 16;
  localparam int SUM_W  = PIX_W + 4;
  localparam int CNT_W  = 10;
  localparam int STAGES = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  // Per-window side data that rides alongside the arithmetic pipeline.
  typedef struct packed {
    logic             brd;
    logic [CNT_W-1:0] col;
    logic [CNT_W-1:0] row;
  } side_t;
endpackage

// File: rtl/gaussian_blur_3x3_if.sv
// Window-in / filtered-pixel-out bundle between line buffer, blur and Sobel stages.
interface gaussian_blur_3x3_if import gauss_pkg::*; #(parameter int DATA_WIDTH = PIX_W);
  logic                  win_en;
  logic                  win_ok;
  logic [DATA_WIDTH-1:0] p11, p12, p13, p21, p22, p23, p31, p32, p33;
  logic [DATA_WIDTH-1:0] pix_out;
  logic                  out_valid;
  logic [CNT_W-1:0]      out_col;
  logic [CNT_W-1:0]      out_row;

  modport master (
    output win_en, win_ok, p11, p12, p13, p21, p22, p23, p31, p32, p33,
    input  pix_out, out_valid, out_col, out_row
  );
  modport slave (
    input  win_en, win_ok, p11, p12, p13, p21, p22, p23, p31, p32, p33,
    output pix_out, out_valid, out_col, out_row
  );
endinterface

// File: rtl/gauss_row_sum.sv
// Weighted 1-2-1 sum a + 2b + c with two bits of growth; used for rows and for the column pass.
module gauss_row_sum import gauss_pkg::*; #(
  parameter int IN_W = PIX_W
) (
  input  logic [IN_W-1:0] a,
  input  logic [IN_W-1:0] b,
  input  logic [IN_W-1:0] c,
  output logic [IN_W+1:0] sum
);
  localparam int OW = IN_W + 2;

  assign sum = OW'(a) * OW'(W_SIDE) + OW'(b) * OW'(W_MID) + OW'(c) * OW'(W_SIDE);
endmodule

// File: rtl/gaussian_blur_3x3.sv
// 3x3 [1 2 1;2 4 2;1 2 1]/16 blur with per-frame column/row tracking and a frame_done pulse.
module gaussian_blur_3x3 import gauss_pkg::*; #(
  parameter int                    WIDTH       = 640,
  parameter int                    DEPTH       = 512,
  parameter int                    KERNEL_SIZE = 3,
  parameter int                    DATA_WIDTH  = PIX_W,
  parameter logic [DATA_WIDTH-1:0] BORDER_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  gaussian_blur_3x3_if.slave  win,
  output logic                frame_done,
  output logic                busy
);
  localparam int RW = DATA_WIDTH + 2;
  localparam int SW = DATA_WIDTH + KSHIFT;

  state_t                         state, state_nxt;
  logic [STAGES:0]                vld_pipe;
  side_t [STAGES:0]               side_pipe;
  side_t                          side_nxt;
  logic [CNT_W-1:0]               col, row;
  logic [1:0]                     drain;
  logic                           acc, last, abort;

  logic [2:0][2:0][DATA_WIDTH-1:0] tap;
  logic [2:0][RW-1:0]             rsum_c, rsum_q;
  logic [SW-1:0]                  csum_c, csum_q;
  logic [DATA_WIDTH-1:0]          rnd_q, pix_q;

  assign acc   = (state == RUN) && win.win_en && win.win_ok;
  assign last  = (col == CNT_W'(WIDTH-1)) && (row == CNT_W'(DEPTH-3));
  assign abort = !start && (state == RUN || state == FLUSH);

  // tap[row][col]; row 0 is the oldest line, col 2 the newest pixel.
  assign tap[0] = {win.p13, win.p12, win.p11};
  assign tap[1] = {win.p23, win.p22, win.p21};
  assign tap[2] = {win.p33, win.p32, win.p31};

  for (genvar i = 0; i < 3; i++) begin : g_row
    gauss_row_sum #(.IN_W(DATA_WIDTH)) u_row (
      .a(tap[i][0]), .b(tap[i][1]), .c(tap[i][2]), .sum(rsum_c[i])
    );
  end

  gauss_row_sum #(.IN_W(RW)) u_col (
    .a(rsum_q[0]), .b(rsum_q[1]), .c(rsum_q[2]), .sum(csum_c)
  );

  assign side_nxt = '{brd: (col < CNT_W'(KERNEL_SIZE-1)), col: col, row: row};

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      side_pipe <= '0;
      rsum_q    <= '0;
      csum_q    <= '0;
      rnd_q     <= '0;
      pix_q     <= '0;
    end else begin
      // Valids shift every cycle; gaps become bubbles, an abort drops everything in flight.
      vld_pipe             <= abort ? '0 : {vld_pipe[STAGES-1:0], acc};
      side_pipe[STAGES:1]  <= side_pipe[STAGES-1:0];
      if (acc) begin
        rsum_q       <= rsum_c;
        side_pipe[0] <= side_nxt;
      end
      csum_q <= csum_c;
      // Max sum 16*(2^DW-1)+ROUND still fits SW bits, so the shifted value never saturates.
      rnd_q  <= DATA_WIDTH'((csum_q + SW'(ROUND)) >> KSHIFT);
      pix_q  <= rnd_q;
    end
  end

  assign win.pix_out   = side_pipe[STAGES].brd ? BORDER_VAL : pix_q;
  assign win.out_valid = vld_pipe[STAGES];
  assign win.out_col   = side_pipe[STAGES].col;
  assign win.out_row   = side_pipe[STAGES].row;

  always_ff @(posedge clk) begin
    if (rst || state == IDLE || abort) begin
      col <= '0;
      row <= '0;
    end else if (acc) begin
      if (col == CNT_W'(WIDTH-1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || state != FLUSH) drain <= '0;
    else                       drain <= drain + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = RUN;
      RUN:   if (!start) state_nxt = IDLE;
             else if (acc && last) state_nxt = FLUSH;
      FLUSH: if (!start) state_nxt = IDLE;
             else if (drain == 2'd3 && vld_pipe[STAGES-1:0] == '0) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state == RUN) || (state == FLUSH);
    frame_done = (state == DONE);
  end
endmodule

// File: doc/gaussian_blur_3x3.md
Name: gaussian_blur_3x3

Overview:
- Downstream consumer of the 3x3 line-buffer window stage in the canny chain.
- Convolves each accepted 3x3 window with the kernel [1 2 1; 2 4 2; 1 2 1]/16 through a 3-stage pipeline.
- Forces left-border windows, which straddle the previous line, to BORDER_VAL.
- Tracks output column/row per frame and pulses frame_done once the last result has left the pipeline. The result feeds the Sobel gradient stage.

Parameters:
- WIDTH, 640: pixels per image line.
- DEPTH, 512: lines per frame.
- KERNEL_SIZE, 3: window size; fixed at 3.
- DATA_WIDTH, 16: pixel width.
- BORDER_VAL, 0: value emitted for invalid border windows.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  frame enable; low forces IDLE.
- win_en  in  1  window-advance strobe; the window is sampled on cycles where it is high.
- win_ok  in  1  line buffer primed; windows accepted only when win_en && win_ok.
- p11..p33  in  DATA_WIDTH each (9 ports)  window, row 1 = oldest line, column 3 = newest pixel.
- pix_out  out  DATA_WIDTH  filtered pixel.
- out_valid  out  1  pix_out valid this cycle.
- out_col  out  10  output column 0..WIDTH-1.
- out_row  out  10  output row 0..DEPTH-3.
- frame_done  out  1  one-cycle pulse after the last output.
- busy  out  1  high in RUN or FLUSH.

Behaviour:
- Reset (rst high at a clk edge): all outputs and counters go to 0, all pipeline valid bits clear, FSM goes to IDLE. This applies equally mid-frame.
- Accept: acc = (state==RUN) && win_en && win_ok.
- Stage 1 (registered on acc): row sums r1 = p11+2*p12+p13, r2 = p21+2*p22+p23, r3 = p31+2*p32+p33. Each is DATA_WIDTH+2 bits unsigned.
- Stage 1 side data: registers the border flag, set when the column counter < KERNEL_SIZE-1.
- Stage 2: s = r1 + 2*r2 + r3, DATA_WIDTH+4 bits.
- Stage 3: pix_out = (s + 8) >> 4, rounding half up. The maximum is (16*65535+8)>>4 = 65535, so no saturation logic is required. If the border flag is set, pix_out = BORDER_VAL instead.
- Latency: acc at edge N gives out_valid high during the cycle after edge N+3.
- The valid bit shifts every cycle regardless of win_en. Input gaps produce output bubbles; there is no stall and no backpressure.
- Column counter: increments on acc and wraps WIDTH-1 -> 0. The row counter increments on that wrap. out_col/out_row travel with the pipeline and are aligned with pix_out.
- Frame length: WIDTH*(DEPTH-2) accepted windows.
- FSM states and transitions:
  - IDLE: counters are held at 0. Go to RUN when start is high.
  - RUN: accept windows. On the acc of the final window (col WIDTH-1, row DEPTH-3), go to FLUSH.
  - FLUSH: a 2-bit drain counter waits until the pipeline valids are empty, then go to DONE.
  - DONE: frame_done=1 for exactly one cycle, then IDLE. A new frame requires start to be seen in IDLE; start held high restarts on the next cycle.
- start low in RUN or FLUSH: go to IDLE next edge, clear counters and pipeline valids, suppress in-flight outputs, no frame_done.
- win_en while win_ok is low: ignored, no counter movement.
- win_en high in FLUSH or DONE: ignored.
- busy = RUN or FLUSH.

Decomposition:
- Shared package gauss_pkg holds:
  - kernel weights and shift (KSHIFT=4, ROUND=8);
  - derived widths SUM_W = DATA_WIDTH+4 and CNT_W = 10;
  - FSM state enum {IDLE, RUN, FLUSH, DONE}.
- One sub-module, gauss_row_sum: the combinational a+2b+c with width growth, instantiated three times in stage 1. Stage 2 reuses it with inputs (r1, r2, r3).

Test Plan:
- Flat field: WIDTH=8, DEPTH=4, every tap = 100, win_ok=1, win_en continuous -> 16 outputs. Columns 0-1 of each row = 0, all others = 100. out_valid appears 3 cycles after the first accept.
- Kernel/rounding: centre-only window p22=16 -> 4; p22=2 -> 1; p11=7 -> 0; p12=4 -> 1 (8+8>>4); all taps 65535 -> 65535 (no overflow).
- Bubbles and ordering: win_en toggles 1/0 -> out_valid follows the same pattern delayed by 3 cycles. out_col/out_row run 0..7/0..1 in order with no duplicates.
- Frame end: last accept at edge t -> out_valid for col 7, row 1 after edge t+3; frame_done pulses exactly one cycle after edge t+4; busy low afterwards.
- Abort/reset: drop start mid-row 1 -> no further out_valid and no frame_done; restart gives outputs from col 0, row 0. Assert rst mid-frame -> all outputs 0 next cycle.
- Gating: win_en=1 with win_ol=0 for 10 cycles -> no outputs and counters stay at 0.
